// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

   localparam int unsigned DEF_WORD_W = 8;
   localparam int unsigned DEF_CNT_W  = 16;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

endpackage

// File: rtl/ccff_tail_crc16.sv
// Serial CRC-16-CCITT (MSB-first, no reflection, no final XOR) over the bits
// returning from the chain tail.
module ccff_tail_crc16
   import ccff_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      fb    = crc_q[15] ^ din;
      crc_d = crc_q;
      if (init) begin
         crc_d = CRC16_INIT;
      end else if (en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words MSB-first onto the configuration chain head.
// Optional tail signature output enabled by defining CCFF_TAIL_CRC_EN.
module ccff_bitstream_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [CNT_W-1:0]  chain_len,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bits_shifted
`ifdef CCFF_TAIL_CRC_EN
   ,
   output logic [15:0]       tail_crc
`endif
);

   localparam int unsigned IDX_W = $clog2(WORD_W);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WORD_W-1:0]  hold_q, hold_d;
   logic [IDX_W-1:0]   rem_q, rem_d;
   logic               head_q, head_d;
   logic               en_q, en_d;

   logic [CNT_W-1:0]   presented;
   logic               can_issue;
   logic               last_bit;
   logic               ready_c;
   logic               take_word;
   logic               start_ok;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      rem_d   = rem_q;
      head_d  = head_q;
      en_d    = 1'b0;

      // Bits already placed on the head (shifted plus the one shifting now).
      presented = cnt_q + CNT_W'(en_q);
      can_issue = presented < len_q;
      last_bit  = en_q && (cnt_q == len_q - CNT_W'(1));
      // rem_q == 0: holding register empty or its last bit is on the head now.
      ready_c   = (state_q == SHIFT) && (rem_q == '0) && can_issue;
      take_word = ready_c && bs_valid;
      start_ok  = (state_q == IDLE) && start;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = chain_len;
               cnt_d   = '0;
               rem_d   = '0;
               state_d = (chain_len == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (en_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if ((rem_q != '0) && can_issue) begin
               head_d = hold_q[WORD_W-1];
               hold_d = {hold_q[WORD_W-2:0], 1'b0};
               rem_d  = rem_q - IDX_W'(1);
               en_d   = 1'b1;
            end else if (take_word) begin
               head_d = bs_data[WORD_W-1];
               hold_d = {bs_data[WORD_W-2:0], 1'b0};
               rem_d  = IDX_W'(WORD_W - 1);
               en_d   = 1'b1;
            end
            if (last_bit) begin
               // Unused low bits of a partial final word are dropped here.
               rem_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         rem_q   <= '0;
         head_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         rem_q   <= rem_d;
         head_q  <= head_d;
         en_q    <= en_d;
      end
   end

   assign bs_ready      = ready_c;
   assign ccff_head     = head_q;
   assign ccff_shift_en = en_q;
   assign busy          = (state_q == SHIFT);
   assign done          = (state_q == DONE);
   assign bits_shifted  = cnt_q;

`ifdef CCFF_TAIL_CRC_EN
   ccff_tail_crc16 u_tail_crc (
      .clk   (prog_clk),
      .rst_n (pReset),
      .init  (start_ok),
      .en    (en_q),
      .din   (ccff_tail),
      .crc   (tail_crc)
   );
`else
   logic unused_tail;
   logic unused_start_ok;
   assign unused_tail     = ccff_tail;
   assign unused_start_ok = start_ok;
`endif

endmodule
